// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared heading encodings and helpers for the snake game
package snake_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_UP    = 2'd0;
    localparam dir_t DIR_DOWN  = 2'd1;
    localparam dir_t DIR_LEFT  = 2'd2;
    localparam dir_t DIR_RIGHT = 2'd3;

    // Encodings pair up so that bit 0 separates a direction from its reversal.
    function automatic dir_t opposite(input dir_t d);
        return {d[1], ~d[0]};
    endfunction

endpackage

// File: rtl/dir_queue_if.sv
// rtl/dir_queue_if.sv - button/tick inputs and heading outputs of dir_queue
interface dir_queue_if #(
    parameter int DEPTH = 2
);
    logic                     up;
    logic                     down;
    logic                     left;
    logic                     right;
    logic                     update_tick;
    logic                     flush;
    logic [1:0]               dir;
    logic                     dir_changed;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output up, down, left, right, update_tick, flush,
        input  dir, dir_changed, count
    );

    modport slave (
        input  up, down, left, right, update_tick, flush,
        output dir, dir_changed, count
    );
endinterface

// File: rtl/dir_queue_press_select.sv
// rtl/dir_queue_press_select.sv - button edge detect and fixed-priority candidate pick
module press_select
    import snake_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic up,
    input  logic down,
    input  logic left,
    input  logic right,
    output logic cand_valid,
    output dir_t cand_dir
);

    logic [3:0] lvl;
    logic [3:0] lvl_q;
    logic [3:0] press;

    assign lvl   = {up, down, left, right};
    assign press = lvl & ~lvl_q;

    // Edge registers always track the current levels, so a flush cycle
    // naturally absorbs held buttons without any extra reload path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) lvl_q <= 4'b0000;
        else       lvl_q <= lvl;
    end

    always_comb begin
        cand_valid = |press;
        cand_dir   = DIR_UP;
        if      (press[3]) cand_dir = DIR_UP;
        else if (press[2]) cand_dir = DIR_DOWN;
        else if (press[1]) cand_dir = DIR_LEFT;
        else if (press[0]) cand_dir = DIR_RIGHT;
    end

endmodule

// File: rtl/dir_queue.sv
// rtl/dir_queue.sv - validated FIFO of player direction presses feeding the heading register
module dir_queue
    import snake_pkg::*;
#(
    parameter int   DEPTH    = 2,
    parameter dir_t INIT_DIR = DIR_RIGHT
) (
    input  logic        clk,
    input  logic        reset,
    dir_queue_if.slave  bus
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic          cand_valid;
    dir_t          cand_dir;
    dir_t          mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] tail_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_after_pop;
    dir_t          dir;
    dir_t          last_dir;
    logic          dir_changed;
    logic          cand_ok;
    logic          push;
    logic          pop;

    press_select u_press_select (
        .clk        (clk),
        .reset      (reset),
        .up         (bus.up),
        .down       (bus.down),
        .left       (bus.left),
        .right      (bus.right),
        .cand_valid (cand_valid),
        .cand_dir   (cand_dir)
    );

    assign tail_ptr        = wr_ptr - PW'(1);
    assign last_dir        = (count != '0) ? mem[tail_ptr] : dir;
    assign cand_ok         = cand_valid && (cand_dir != last_dir) && (cand_dir != opposite(last_dir));
    assign pop             = bus.update_tick && (count != '0);
    assign count_after_pop = count - CW'(pop);
    // An empty-FIFO pop never reaches the entry pushed this cycle; it commits next tick.
    assign push            = cand_ok && (count_after_pop < DEPTH_C);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            dir         <= INIT_DIR;
            dir_changed <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= INIT_DIR;
        end else if (bus.flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            dir         <= INIT_DIR;
            dir_changed <= 1'b0;
        end else begin
            dir_changed <= pop;
            if (push) begin
                mem[wr_ptr] <= cand_dir;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                dir    <= mem[rd_ptr];
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count_after_pop + CW'(push);
        end
    end

    assign bus.dir         = dir;
    assign bus.dir_changed = dir_changed;
    assign bus.count       = count;

endmodule
